// File: rtl/fast_square_pkg.sv
// Shared definitions for the fast-square frequency-step link: responder FSM
// states, default sweep length and a small counter-width helper.
package fast_square_pkg;

   // Steps per sweep, shared with fast_square_controller.
   localparam int DEFAULT_NUM_FREQ_STEPS = 32;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      LOAD       = 3'd1,
      SHIFT_LO   = 3'd2,
      SHIFT_HI   = 3'd3,
      LATCH      = 3'd4,
      SYNC_PULSE = 3'd5
   } fsm_state_e;

   // Bits needed to count 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/fast_square_edge_sync.sv
// Two-flop synchronizer for an asynchronous level plus a third flop used to
// detect its rising edge; produces a one-cycle event per rising edge.
module fast_square_edge_sync
   import fast_square_pkg::*;
(
   input  logic clk64,
   input  logic reset,
   input  logic async_in,
   output logic rise_evt
);

   logic s1_r;
   logic s2_r;
   logic s3_r;

   // Synchronizer chain and edge-detect delay flop, cleared by reset.
   always_ff @(posedge clk64) begin
      if (!reset) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= async_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   assign rise_evt = s2_r & ~s3_r;

endmodule

// File: rtl/fast_square_step_responder.sv
// Synth-side end of the fast-square step link. Each freq_step edge advances
// the step index and programs the matching synthesizer word over a 3-wire
// serial bus (sclk/sdata/le); a sweep wrap emits a sweep_reset pulse.
module fast_square_step_responder
   import fast_square_pkg::*;
#(
   parameter int                  NUM_FREQ_STEPS    = DEFAULT_NUM_FREQ_STEPS,
   parameter int                  WORD_BITS         = 24,
   parameter logic [WORD_BITS-1:0] BASE_WORD        = 24'h010000,
   parameter logic [WORD_BITS-1:0] STEP_WORD        = 24'h000100,
   parameter int                  SCLK_DIV          = 4,
   parameter int                  RESET_PULSE_TICKS = 64
)
(
   input  logic                              clk64,
   input  logic                              reset,
   input  logic                              step_in,
   input  logic                              enable,
   output logic                              syn_sclk,
   output logic                              syn_sdata,
   output logic                              syn_le,
   output logic                              sweep_reset,
   output logic [$clog2(NUM_FREQ_STEPS)-1:0] step_index,
   output logic                              busy,
   output logic                              overrun
);

   localparam int IDX_W   = cnt_width(NUM_FREQ_STEPS);
   localparam int DIV_W   = cnt_width(SCLK_DIV);
   localparam int BIT_W   = cnt_width(WORD_BITS + 1);
   localparam int PULSE_W = cnt_width(RESET_PULSE_TICKS);

   fsm_state_e           state_r, state_s;
   logic [DIV_W-1:0]     div_r, div_s;
   logic [BIT_W-1:0]     bit_r, bit_s;
   logic [PULSE_W-1:0]   pulse_r, pulse_s;
   logic [WORD_BITS-1:0] sr_r, sr_s;
   logic [WORD_BITS-1:0] word_r, word_s;
   logic [IDX_W-1:0]     index_r, index_s;
   logic                 armed_r, armed_s;
   logic                 pending_r, pending_s;
   logic                 overrun_r, overrun_s;
   logic                 sclk_r, sclk_s;
   logic                 sdata_r, sdata_s;
   logic                 le_r, le_s;
   logic                 sweep_r, sweep_s;
   logic                 busy_r, busy_s;
   logic [IDX_W-1:0]     step_index_r, step_index_s;
   logic                 step_evt_s;
   logic                 step_ok_s;
   logic                 div_last_s;

   fast_square_edge_sync u_step_sync (
      .clk64    (clk64),
      .reset    (reset),
      .async_in (step_in),
      .rise_evt (step_evt_s)
   );

   assign step_ok_s  = step_evt_s & enable;
   assign div_last_s = (div_r == DIV_W'(SCLK_DIV - 1));

   // FSM state register.
   always_ff @(posedge clk64) begin
      if (!reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state plus counter, index/word accumulator and shift-register updates.
   always_comb begin
      state_s = state_r;
      div_s   = div_r;
      bit_s   = bit_r;
      pulse_s = pulse_r;
      sr_s    = sr_r;
      word_s  = word_r;
      index_s = index_r;
      armed_s = armed_r;
      case (state_r)
         IDLE: begin
            if (step_ok_s || (pending_r && enable)) begin
               state_s = LOAD;
            end else begin
               state_s = IDLE;
            end
         end
         LOAD: begin
            // The accumulator replaces BASE_WORD + index*STEP_WORD.
            if (index_r == IDX_W'(NUM_FREQ_STEPS - 1)) begin
               index_s = {IDX_W{1'b0}};
               word_s  = BASE_WORD;
               armed_s = 1'b1;
            end else begin
               index_s = index_r + IDX_W'(1);
               word_s  = word_r + STEP_WORD;
               armed_s = armed_r;
            end
            sr_s    = word_s;
            div_s   = {DIV_W{1'b0}};
            bit_s   = BIT_W'(WORD_BITS);
            state_s = SHIFT_LO;
         end
         SHIFT_LO: begin
            if (div_last_s) begin
               div_s   = {DIV_W{1'b0}};
               state_s = SHIFT_HI;
            end else begin
               div_s   = div_r + DIV_W'(1);
            end
         end
         SHIFT_HI: begin
            if (div_last_s) begin
               div_s = {DIV_W{1'b0}};
               sr_s  = {sr_r[WORD_BITS-2:0], 1'b0};
               bit_s = bit_r - BIT_W'(1);
               if (bit_r == BIT_W'(1)) begin
                  state_s = LATCH;
               end else begin
                  state_s = SHIFT_LO;
               end
            end else begin
               div_s = div_r + DIV_W'(1);
            end
         end
         LATCH: begin
            if (div_last_s) begin
               div_s = {DIV_W{1'b0}};
               if (armed_r) begin
                  armed_s = 1'b0;
                  pulse_s = {PULSE_W{1'b0}};
                  state_s = SYNC_PULSE;
               end else begin
                  state_s = IDLE;
               end
            end else begin
               div_s = div_r + DIV_W'(1);
            end
         end
         SYNC_PULSE: begin
            if (pulse_r == PULSE_W'(RESET_PULSE_TICKS - 1)) begin
               state_s = IDLE;
            end else begin
               pulse_s = pulse_r + PULSE_W'(1);
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Step handshake: one step may wait behind a busy frame; a further one is lost.
   always_comb begin
      pending_s = pending_r;
      overrun_s = overrun_r;
      if (!enable) begin
         pending_s = 1'b0;
      end else if (state_r == LOAD) begin
         pending_s = step_evt_s;
      end else if (step_evt_s) begin
         if (pending_r) begin
            overrun_s = 1'b1;
         end else if (state_r != IDLE) begin
            pending_s = 1'b1;
         end else begin
            pending_s = 1'b0;
         end
      end else begin
         pending_s = pending_r;
      end
   end

   // Output values derived from the next state so the pins change with the state.
   always_comb begin
      sclk_s  = (state_s == SHIFT_HI);
      le_s    = (state_s == LATCH);
      sweep_s = (state_s == SYNC_PULSE);
      busy_s  = (state_s == LOAD) || (state_s == SHIFT_LO) ||
                (state_s == SHIFT_HI) || (state_s == LATCH);
      if ((state_s == SHIFT_LO) || (state_s == SHIFT_HI)) begin
         sdata_s = sr_s[WORD_BITS-1];
      end else begin
         sdata_s = 1'b0;
      end
      // Published index follows the word the synthesizer has just latched.
      if (state_r == LATCH) begin
         step_index_s = index_r;
      end else begin
         step_index_s = step_index_r;
      end
   end

   // Datapath and registered outputs; reset aborts any frame in flight.
   always_ff @(posedge clk64) begin
      if (!reset) begin
         div_r        <= {DIV_W{1'b0}};
         bit_r        <= {BIT_W{1'b0}};
         pulse_r      <= {PULSE_W{1'b0}};
         sr_r         <= {WORD_BITS{1'b0}};
         word_r       <= BASE_WORD;
         index_r      <= {IDX_W{1'b0}};
         armed_r      <= 1'b0;
         pending_r    <= 1'b0;
         overrun_r    <= 1'b0;
         sclk_r       <= 1'b0;
         sdata_r      <= 1'b0;
         le_r         <= 1'b0;
         sweep_r      <= 1'b0;
         busy_r       <= 1'b0;
         step_index_r <= {IDX_W{1'b0}};
      end else begin
         div_r        <= div_s;
         bit_r        <= bit_s;
         pulse_r      <= pulse_s;
         sr_r         <= sr_s;
         word_r       <= word_s;
         index_r      <= index_s;
         armed_r      <= armed_s;
         pending_r    <= pending_s;
         overrun_r    <= overrun_s;
         sclk_r       <= sclk_s;
         sdata_r      <= sdata_s;
         le_r         <= le_s;
         sweep_r      <= sweep_s;
         busy_r       <= busy_s;
         step_index_r <= step_index_s;
      end
   end

   assign syn_sclk    = sclk_r;
   assign syn_sdata   = sdata_r;
   assign syn_le      = le_r;
   assign sweep_reset = sweep_r;
   assign busy        = busy_r;
   assign overrun     = overrun_r;
   assign step_index  = step_index_r;

endmodule

// File: tb/tb_fast_square_step_responder.sv
// Self-checking bench for fast_square_step_responder: table-driven step
// scenarios, hand-written reset/glitch sequences and randomized spaced steps,
// all checked against a word/index model of the sweep.
module tb_fast_square_step_responder;

   localparam int N_STEPS   = 32;
   localparam int BASE      = 'h010000;
   localparam int STEP      = 'h000100;
   localparam int LE_LEN    = 4;
   localparam int PULSE_LEN = 64;
   localparam int FRAME_LEN = 2 * 4 * 24 + 4 + 1;

   logic       clk64 = 1'b0;
   logic       reset = 1'b0;
   logic       step_in = 1'b0;
   logic       enable = 1'b1;
   logic       syn_sclk, syn_sdata, syn_le, sweep_reset, busy, overrun;
   logic [4:0] step_index;

   fast_square_step_responder dut (
      .clk64       (clk64),
      .reset       (reset),
      .step_in     (step_in),
      .enable      (enable),
      .syn_sclk    (syn_sclk),
      .syn_sdata   (syn_sdata),
      .syn_le      (syn_le),
      .sweep_reset (sweep_reset),
      .step_index  (step_index),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk64 = ~clk64;

   int n_checks = 0;
   int n_fail   = 0;

   // Monitor state (written only by the monitor process)
   logic [23:0] rx_q[$];
   int          rxbits_q[$];
   int          cyc = 0;
   int          sclk_rises = 0, sweeps = 0;
   int          le_len = 0, sw_len = 0, busy_len = 0;
   int          le_fall_cyc = -1, sw_rise_cyc = -2;

   // Model state
   logic [23:0] exp_q[$];
   int          m_idx = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] model_word(input int idx);
      int w;
      w = BASE + idx * STEP;
      return w[23:0];
   endfunction

   // Model: one accepted step advances the index and names the next word.
   task automatic model_step();
      m_idx = (m_idx + 1) % N_STEPS;
      exp_q.push_back(model_word(m_idx));
   endtask

   // Serial-bus monitor sampled on the falling clock edge.
   initial begin
      logic [23:0] cap;
      int nbits, le_cnt, sw_cnt, busy_cnt;
      logic p_sclk, p_le, p_sw, p_busy;
      cap = '0; nbits = 0; le_cnt = 0; sw_cnt = 0; busy_cnt = 0;
      p_sclk = 1'b0; p_le = 1'b0; p_sw = 1'b0; p_busy = 1'b0;
      forever begin
         @(negedge clk64);
         cyc++;
         if (!reset) begin
            cap = '0; nbits = 0; le_cnt = 0; sw_cnt = 0; busy_cnt = 0;
            p_sclk = 1'b0; p_le = 1'b0; p_sw = 1'b0; p_busy = 1'b0;
         end else begin
            if (syn_sclk && !p_sclk) begin
               cap = {cap[22:0], syn_sdata};
               nbits++;
               sclk_rises++;
            end
            if (syn_le && !p_le) begin
               rx_q.push_back(cap);
               rxbits_q.push_back(nbits);
               cap = '0;
               nbits = 0;
            end
            if (syn_le) le_cnt++;
            if (!syn_le && p_le) begin le_len = le_cnt; le_cnt = 0; le_fall_cyc = cyc; end
            if (sweep_reset) sw_cnt++;
            if (sweep_reset && !p_sw) begin sweeps++; sw_rise_cyc = cyc; end
            if (!sweep_reset && p_sw) begin sw_len = sw_cnt; sw_cnt = 0; end
            if (busy) busy_cnt++;
            if (!busy && p_busy) begin busy_len = busy_cnt; busy_cnt = 0; end
            p_sclk = syn_sclk; p_le = syn_le; p_sw = sweep_reset; p_busy = busy;
         end
      end
   end

   task automatic pulse_step();
      @(posedge clk64); #1 step_in = 1'b1;
      repeat (2) @(posedge clk64);
      #1 step_in = 1'b0;
   endtask

   // Wait until the bus and sweep line have been idle 8 cycles (bounded).
   task automatic wait_quiet();
      int quiet, budget;
      quiet = 0; budget = 0;
      while (quiet < 8 && budget < 2000) begin
         @(negedge clk64);
         budget++;
         if (!busy && !sweep_reset && !syn_le) quiet++;
         else quiet = 0;
      end
      if (quiet < 8) check("quiet_timeout", 32'(quiet), 32'd8);
   endtask

   task automatic compare_frames(input string tag);
      int n;
      check({tag, "_frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
      n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_word"}, 32'(rx_q[i]), 32'(exp_q[i]));
         check({tag, "_bits"}, 32'(rxbits_q[i]), 32'd24);
      end
      rx_q.delete(); rxbits_q.delete(); exp_q.delete();
   endtask

   typedef struct {
      string name;
      int    n_steps;
      bit    en;
      int    gap;          // 0: wait for idle between steps, else cycles between step edges
      int    exp_frames;
      bit    exp_overrun;
      int    exp_sweeps;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int r0, s0;
      tbl[0] = '{"single",     1, 1'b1, 0,  1, 1'b0, 0};
      tbl[1] = '{"sweep",     31, 1'b1, 0, 31, 1'b0, 1};
      tbl[2] = '{"disabled",   3, 1'b0, 0,  0, 1'b0, 0};
      tbl[3] = '{"reenable",   1, 1'b1, 0,  1, 1'b0, 0};
      tbl[4] = '{"backtoback", 2, 1'b1, 10, 2, 1'b0, 0};
      tbl[5] = '{"overrun",    3, 1'b1, 10, 2, 1'b1, 0};

      // Reset state
      repeat (5) @(posedge clk64);
      @(negedge clk64);
      check("rst_sclk", 32'(syn_sclk), 32'd0);
      check("rst_sdata", 32'(syn_sdata), 32'd0);
      check("rst_le", 32'(syn_le), 32'd0);
      check("rst_sweep", 32'(sweep_reset), 32'd0);
      check("rst_index", 32'(step_index), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      @(posedge clk64); #1 reset = 1'b1;
      repeat (20) @(posedge clk64);
      check("no_poweron_frame", 32'(rx_q.size()), 32'd0);

      // Table-driven scenarios
      for (int t = 0; t < 6; t++) begin
         enable = tbl[t].en;
         r0 = sclk_rises; s0 = sweeps;
         for (int k = 0; k < tbl[t].n_steps; k++) begin
            pulse_step();
            if (tbl[t].gap == 0) wait_quiet();
            else repeat (tbl[t].gap - 3) @(posedge clk64);
         end
         wait_quiet();
         if (tbl[t].en) begin
            for (int k = 0; k < tbl[t].exp_frames; k++) model_step();
         end
         compare_frames(tbl[t].name);
         check({tbl[t].name, "_sclk_edges"}, 32'(sclk_rises - r0), 32'(24 * tbl[t].exp_frames));
         check({tbl[t].name, "_index"}, 32'(step_index), 32'(m_idx));
         check({tbl[t].name, "_overrun"}, 32'(overrun), 32'(tbl[t].exp_overrun));
         check({tbl[t].name, "_sweeps"}, 32'(sweeps - s0), 32'(tbl[t].exp_sweeps));
         if (tbl[t].exp_frames > 0) begin
            check({tbl[t].name, "_le_len"}, 32'(le_len), 32'(LE_LEN));
            check({tbl[t].name, "_busy_len"}, 32'(busy_len), 32'(FRAME_LEN));
         end
         if (tbl[t].exp_sweeps > 0) begin
            check({tbl[t].name, "_sweep_len"}, 32'(sw_len), 32'(PULSE_LEN));
            check({tbl[t].name, "_sweep_align"}, 32'(sw_rise_cyc), 32'(le_fall_cyc));
         end
      end

      // Reset in the middle of SHIFT_HI
      begin
         int budget;
         pulse_step();
         budget = 0;
         while (!syn_sclk && budget < 50) begin @(negedge clk64); budget++; end
         check("midrst_reached_shift_hi", 32'(syn_sclk), 32'd1);
         @(posedge clk64); #1 reset = 1'b0;
         @(posedge clk64); #1;
         check("midrst_sclk", 32'(syn_sclk), 32'd0);
         check("midrst_le", 32'(syn_le), 32'd0);
         check("midrst_busy", 32'(busy), 32'd0);
         check("midrst_index", 32'(step_index), 32'd0);
         check("midrst_overrun", 32'(overrun), 32'd0);
         repeat (2) @(posedge clk64);
         #1 reset = 1'b1;
         rx_q.delete(); rxbits_q.delete(); exp_q.delete();
         m_idx = 0;
         repeat (5) @(posedge clk64);
         pulse_step();
         wait_quiet();
         model_step();
         compare_frames("postrst");
         check("postrst_index", 32'(step_index), 32'(m_idx));
      end

      // Sub-cycle glitch on step_in straddling one rising edge
      @(negedge clk64); #4 step_in = 1'b1;
      #3 step_in = 1'b0;
      wait_quiet();
      model_step();
      compare_frames("glitch");
      check("glitch_index", 32'(step_index), 32'(m_idx));

      // Randomized spaced steps with random enable, against the model
      begin
         int s_start, m_wraps;
         bit en;
         s_start = sweeps; m_wraps = 0;
         for (int r = 0; r < 48; r++) begin
            en = ($urandom_range(0, 4) != 0);
            enable = en;
            pulse_step();
            wait_quiet();
            if (en) begin
               model_step();
               if (m_idx == 0) m_wraps++;
            end
            repeat ($urandom_range(0, 15)) @(posedge clk64);
         end
         enable = 1'b1;
         compare_frames("random");
         check("random_index", 32'(step_index), 32'(m_idx));
         check("random_sweeps", 32'(sweeps - s_start), 32'(m_wraps));
         check("random_overrun", 32'(overrun), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
